// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one fifo_xb enqueue/din port among NREQ requesters.
// A grant lasts up to BURST words; handoff always passes through one IDLE cycle.
module fifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    enqueue,
  output logic [WIDTH-1:0]        din,
  input  logic                    full,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [IW:0]   NREQ_W   = (IW + 1)'(NREQ);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST - 1);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] lane [NREQ];
  logic [NREQ-1:0]  rot_valid;
  logic [IW:0]      win_off;
  logic [IW:0]      win_sum;
  logic [IW-1:0]    winner;
  logic [IW:0]      own_sum;
  logic [IW-1:0]    owner_inc;
  logic             own_valid;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Rotate so that bit 0 corresponds to ptr; the lowest set bit is the winner's offset.
  assign rot_valid = (req_valid >> ptr_q) | (req_valid << (NREQ_W - {1'b0, ptr_q}));

  always_comb begin
    win_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        win_off = (IW + 1)'(k);
      end
    end
  end

  always_comb begin
    win_sum = {1'b0, ptr_q} + win_off;
    if (win_sum >= NREQ_W) begin
      win_sum = win_sum - NREQ_W;
    end
    winner = win_sum[IW-1:0];
  end

  always_comb begin
    own_sum = {1'b0, owner_q} + (IW + 1)'(1);
    if (own_sum >= NREQ_W) begin
      own_sum = '0;
    end
    owner_inc = own_sum[IW-1:0];
  end

  assign own_valid = req_valid[owner_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    enqueue   = 1'b0;
    din       = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d = winner;
          cnt_d   = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        req_ready = full ? '0 : (NREQ'(1) << owner_q);
        enqueue   = own_valid & ~full;
        din       = lane[owner_q];
        // A dropped valid or the last word of the burst both hand priority to owner+1.
        if (!own_valid || (enqueue && (cnt_q == LAST_CNT))) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
          cnt_d   = '0;
        end else if (enqueue) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q == OWN);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: reset, single requester, round-robin, full stall,
// early release and reset mid-burst, each with hand-computed expectations.
module tb_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [7:0]  lane [4];
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        enqueue;
  logic [7:0]  din;
  logic        full = 1'b0;
  logic [1:0]  owner;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign req_data = {lane[3], lane[2], lane[1], lane[0]};

  fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .enqueue   (enqueue),
    .din       (din),
    .full      (full),
    .owner     (owner),
    .busy      (busy)
  );

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'b0000;
    full = 1'b0;
    for (int i = 0; i < 4; i++) lane[i] = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (enqueue !== 1'b0) begin bad++; $display("FAIL reset_enq c=%0d got=%b want=0", c, enqueue); end
      total++;
      if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready c=%0d got=%b want=0000", c, req_ready); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy c=%0d got=%b want=0", c, busy); end
      total++;
      if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner c=%0d got=%0d want=0", c, owner); end
      total++;
      if (din !== 8'h00) begin bad++; $display("FAIL reset_din c=%0d got=%h want=00", c, din); end
      tick();
    end
  endtask

  task automatic test_single();
    int   words;
    logic exp_enq;
    logic [7:0] exp_din;
    do_reset();
    words = 0;
    lane[2] = 8'h10;
    req_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      exp_enq = ((c % 5) != 0);
      exp_din = 8'h10 + 8'(words);
      @(negedge clk);
      total++;
      if (enqueue !== exp_enq) begin bad++; $display("FAIL single_enq c=%0d got=%b want=%b", c, enqueue, exp_enq); end
      total++;
      if (busy !== exp_enq) begin bad++; $display("FAIL single_busy c=%0d got=%b want=%b", c, busy, exp_enq); end
      if (exp_enq) begin
        total++;
        if (din !== exp_din) begin bad++; $display("FAIL single_din c=%0d got=%h want=%h", c, din, exp_din); end
        total++;
        if (owner !== 2'd2) begin bad++; $display("FAIL single_owner c=%0d got=%0d want=2", c, owner); end
      end
      if (enqueue === 1'b1) $display("txn single c=%0d owner=%0d din=%h", c, owner, din);
      tick();
      if (exp_enq) begin
        words++;
        lane[2] = 8'h10 + 8'(words);
      end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_round_robin();
    int   wc [4];
    int   enq_count;
    int   o;
    logic exp_enq;
    logic [7:0] exp_din;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wc[i] = 0;
      lane[i] = 8'(i * 16);
    end
    enq_count = 0;
    req_valid = 4'b1111;
    for (int c = 0; c < 22; c++) begin
      o = (c / 5) % 4;
      exp_enq = ((c % 5) != 0);
      exp_din = 8'(o * 16 + wc[o]);
      @(negedge clk);
      if (c < 20 && enqueue === 1'b1) enq_count++;
      total++;
      if (enqueue !== exp_enq) begin bad++; $display("FAIL rr_enq c=%0d got=%b want=%b", c, enqueue, exp_enq); end
      if (exp_enq) begin
        total++;
        if (owner !== 2'(o)) begin bad++; $display("FAIL rr_owner c=%0d got=%0d want=%0d", c, owner, o); end
        total++;
        if (din !== exp_din) begin bad++; $display("FAIL rr_din c=%0d got=%h want=%h", c, din, exp_din); end
      end
      if (enqueue === 1'b1) $display("txn rr c=%0d owner=%0d din=%h", c, owner, din);
      tick();
      if (exp_enq) begin
        wc[o]++;
        lane[o] = 8'(o * 16 + wc[o]);
      end
    end
    total++;
    if (enq_count != 16) begin bad++; $display("FAIL rr_count got=%0d want=16", enq_count); end
    req_valid = 4'b0000;
  endtask

  task automatic test_full_stall();
    int   words;
    logic exp_enq;
    logic exp_busy;
    logic [3:0] exp_ready;
    logic [7:0] exp_din;
    do_reset();
    words = 0;
    lane[1] = 8'h20;
    req_valid = 4'b0010;
    for (int c = 0; c < 11; c++) begin
      full = (c >= 3 && c <= 7);
      exp_enq = (c == 1 || c == 2 || c == 8 || c == 9);
      exp_busy = (c >= 1 && c <= 9);
      exp_ready = (exp_busy && !full) ? 4'b0010 : 4'b0000;
      exp_din = 8'h20 + 8'(words);
      @(negedge clk);
      total++;
      if (enqueue !== exp_enq) begin bad++; $display("FAIL stall_enq c=%0d got=%b want=%b", c, enqueue, exp_enq); end
      total++;
      if (busy !== exp_busy) begin bad++; $display("FAIL stall_busy c=%0d got=%b want=%b", c, busy, exp_busy); end
      total++;
      if (req_ready !== exp_ready) begin bad++; $display("FAIL stall_ready c=%0d got=%b want=%b", c, req_ready, exp_ready); end
      if (exp_busy) begin
        total++;
        if (owner !== 2'd1) begin bad++; $display("FAIL stall_owner c=%0d got=%0d want=1", c, owner); end
      end
      if (exp_enq) begin
        total++;
        if (din !== exp_din) begin bad++; $display("FAIL stall_din c=%0d got=%h want=%h", c, din, exp_din); end
      end
      if (enqueue === 1'b1) $display("txn stall c=%0d owner=%0d din=%h", c, owner, din);
      tick();
      if (exp_enq) begin
        words++;
        lane[1] = 8'h20 + 8'(words);
      end
    end
    full = 1'b0;
    req_valid = 4'b0000;
  endtask

  task automatic test_early_release();
    do_reset();
    lane[3] = 8'h30;
    lane[0] = 8'h50;
    lane[1] = 8'h60;
    req_valid = 4'b1000;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL early_idle0 got=%b want=0", busy); end
    tick();
    @(negedge clk);
    total++;
    if ({busy, owner, enqueue} !== {1'b1, 2'd3, 1'b1}) begin
      bad++; $display("FAIL early_own3 got busy=%b owner=%0d enq=%b want 1/3/1", busy, owner, enqueue);
    end
    total++;
    if (din !== 8'h30) begin bad++; $display("FAIL early_din3 got=%h want=30", din); end
    if (enqueue === 1'b1) $display("txn early owner=%0d din=%h", owner, din);
    tick();
    lane[3] = 8'h31;
    req_valid = 4'b0011;
    @(negedge clk);
    total++;
    if ({busy, owner, enqueue} !== {1'b1, 2'd3, 1'b0}) begin
      bad++; $display("FAIL early_drop got busy=%b owner=%0d enq=%b want 1/3/0", busy, owner, enqueue);
    end
    tick();
    @(negedge clk);
    total++;
    if ({busy, enqueue} !== 2'b00) begin bad++; $display("FAIL early_gap got busy=%b enq=%b want 0/0", busy, enqueue); end
    tick();
    @(negedge clk);
    total++;
    if ({busy, owner, enqueue} !== {1'b1, 2'd0, 1'b1}) begin
      bad++; $display("FAIL early_next got busy=%b owner=%0d enq=%b want 1/0/1", busy, owner, enqueue);
    end
    total++;
    if (din !== 8'h50) begin bad++; $display("FAIL early_din0 got=%h want=50", din); end
    if (enqueue === 1'b1) $display("txn early owner=%0d din=%h", owner, din);
    tick();
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    // Requester 2 completes a burst first so the pointer sits at 3 before the reset.
    lane[2] = 8'hA0;
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) tick();
    lane[0] = 8'h40;
    lane[1] = 8'h60;
    lane[3] = 8'h70;
    req_valid = 4'b0001;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_gap got=%b want=0", busy); end
    tick();
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      total++;
      if ({busy, owner, enqueue} !== {1'b1, 2'd0, 1'b1}) begin
        bad++; $display("FAIL midrst_own w=%0d got busy=%b owner=%0d enq=%b want 1/0/1", w, busy, owner, enqueue);
      end
      total++;
      if (din !== 8'h40 + 8'(w)) begin bad++; $display("FAIL midrst_din w=%0d got=%h want=%h", w, din, 8'h40 + 8'(w)); end
      if (enqueue === 1'b1) $display("txn midrst owner=%0d din=%h", owner, din);
      tick();
      lane[0] = 8'h41 + 8'(w);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    total++;
    if ({busy, enqueue, req_ready} !== 6'b000000) begin
      bad++; $display("FAIL midrst_after got busy=%b enq=%b ready=%b want 0/0/0000", busy, enqueue, req_ready);
    end
    tick();
    @(negedge clk);
    total++;
    if ({busy, owner, enqueue} !== {1'b1, 2'd0, 1'b1}) begin
      bad++; $display("FAIL midrst_restart got busy=%b owner=%0d enq=%b want 1/0/1", busy, owner, enqueue);
    end
    total++;
    if (din !== 8'h42) begin bad++; $display("FAIL midrst_din2 got=%h want=42", din); end
    if (enqueue === 1'b1) $display("txn midrst owner=%0d din=%h", owner, din);
    tick();
    req_valid = 4'b0000;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) lane[i] = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin write-port arbiter that shares one fifo_xb enqueue/din port among NREQ requesters.
- A winning requester owns the port for a burst of up to BURST words. Ownership ends early if the requester drops valid.
- Sits between the producer blocks and the fifo_xb instance. Drives enqueue/din and observes full.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data word width; matches fifo_xb WIDTH.
- BURST, 4, maximum words transferred per grant (1..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  requester i has a word on its data lane.
- req_data  input  NREQ*WIDTH  packed lanes; requester i uses [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  requester i's word is accepted this cycle (one-hot or zero).
- enqueue  output  1  to fifo_xb enqueue.
- din  output  WIDTH  to fifo_xb din.
- full  input  1  from fifo_xb full.
- owner  output  $clog2(NREQ)  index of the current grant holder. Valid while busy=1.
- busy  output  1  1 in OWN state.

Behaviour:
- Single clock domain; all state updates on the rising clk edge.
- Reset when rst=1 at an edge:
  - state=IDLE, ptr=0, owner=0, cnt=0.
  - Outputs: enqueue=0, req_ready=0, busy=0, din=0.
  - Reset mid-burst abandons the burst immediately. No enqueue occurs in the reset cycle's successor.
- State register has two states: IDLE and OWN.
- IDLE:
  - enqueue=0, req_ready=0, din=0.
  - If any req_valid=1, choose the first asserted index scanning ptr, ptr+1, … mod NREQ.
  - Next cycle: owner=winner, cnt=0, state=OWN.
  - If no req_valid is asserted, remain in IDLE.
- OWN outputs (combinational from registered state and inputs):
  - req_ready[owner] = ~full; all other req_ready bits are 0.
  - enqueue = req_valid[owner] & ~full.
  - din = req_data lane [owner].
- OWN transfer: when enqueue=1, cnt increments.
- OWN, burst complete: if enqueue=1 and cnt==BURST-1, release at the edge: state=IDLE, ptr=(owner+1) mod NREQ, cnt=0.
- OWN, early release: if req_valid[owner]=0, release at the edge the same way (ptr=owner+1). No word is transferred that cycle.
- OWN, full=1 with req_valid[owner]=1:
  - Stall: enqueue=0, cnt unchanged, no release.
  - Ownership is held indefinitely while full persists.
- Handoff costs exactly one IDLE cycle, so sustained throughput is BURST words per BURST+1 cycles under contention.
- Fairness: the just-released owner has lowest priority in the next arbitration. A requester waits at most (NREQ-1)*(BURST+1) non-stall cycles.
- Other requesters' req_valid changes during OWN are ignored until the next IDLE.
- A requester must hold req_data stable while req_valid=1 and req_ready=0.
- owner and ptr wrap modulo NREQ; NREQ need not be a power of two.
- cnt width is $clog2(BURST+1).
- enqueue is never asserted when full=1; fifo_xb overflow is impossible by construction.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all req_valid=0 → enqueue=0, req_ready=0, busy=0, owner=0 for 10 cycles.
- Single requester, NREQ=4, BURST=4: req_valid=4'b0100 held, lane2 data 0x10,0x11,… →
  - Cycle 1 IDLE, then 4 enqueues of 0x10..0x13 with owner=2, then 1 IDLE cycle.
  - Next burst delivers 0x14..0x17 (ptr=3 wraps to 2).
- Round-robin: all four req_valid held → grant order 0,1,2,3,0, each with 4 words and a 1-cycle gap; the FIFO receives 16 words in 20 cycles.
- Full stall: requester 1 owns with cnt=2, full=1 for 5 cycles →
  - enqueue=0 and req_ready=0 throughout; owner stays 1 and cnt stays 2.
  - After full drops, exactly 2 more words transfer, then release.
- Early release: requester 3 owns, sends 1 word, drops req_valid → next edge IDLE. ptr=0, so requester 0 wins over requester 1 when both are pending.
- Reset mid-burst: rst=1 at cnt=2 while requester 0 owns → next cycle busy=0, enqueue=0, ptr=0. After rst deasserts, arbitration restarts from index 0.
